// File: rtl/ecc_point_add.sv
// Elliptic-curve point add/double over GF(p) with one shared modular multiplier.
// The latency is fixed: out_valid rises in the cycle after the 20th edge following the accepted in_valid.
module ecc_point_add #(
  parameter int W     = 6,
  parameter int EXP_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [5:0]   in_Px,
  input  logic [5:0]   in_Py,
  input  logic [5:0]   in_Qx,
  input  logic [5:0]   in_Qy,
  input  logic [5:0]   in_prime,
  input  logic [5:0]   in_a,
  output logic         out_valid,
  output logic [5:0]   out_Rx,
  output logic [5:0]   out_Ry
);

  typedef enum logic [2:0] {IDLE, NUM, INV, SLOPE, RX, RY, OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [W-1:0] px_q, py_q, qx_q, qy_q, p_q, a_q;
  logic [W-1:0] num_q, den_q, acc_q, s_q, t_q, rx_q, ry_q;
  logic         out_valid_q;
  logic [W-1:0] out_rx_q, out_ry_q;

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] p);
    logic [W:0] sum;
    sum = {1'b0, x} + {1'b0, p} - {1'b0, y};
    return W'(sum % {1'b0, p});
  endfunction

  // Shared multiplier operand select
  logic [W-1:0]   mul_a, mul_b, mul_r;
  logic [2*W-1:0] prod;
  logic           dbl, exp_bit, degen;
  logic [W-1:0]   exp_v;
  logic [2:0]     bidx;

  assign dbl   = (px_q == qx_q) && (py_q == qy_q);
  assign degen = (den_q == '0);
  assign exp_v = p_q - W'(2);
  assign bidx  = 3'(EXP_W - 1) - cnt_q[3:1];
  assign exp_bit = exp_v[bidx];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      NUM:   begin mul_a = px_q;  mul_b = px_q; end
      INV:   begin mul_a = acc_q; mul_b = cnt_q[0] ? den_q : acc_q; end
      SLOPE: begin mul_a = num_q; mul_b = acc_q; end
      RX:    begin mul_a = s_q;   mul_b = s_q; end
      RY:    begin mul_a = s_q;   mul_b = sub_mod(px_q, rx_q, p_q); end
      default: ;
    endcase
  end

  assign prod  = mul_a * mul_b;
  assign mul_r = W'(prod % {{W{1'b0}}, p_q});

  logic [W+2:0] n3;
  logic [W:0]   y2;
  logic [W+1:0] rxs;
  assign n3  = ({3'b0, t_q} << 1) + {3'b0, t_q} + {3'b0, a_q};
  assign y2  = {py_q, 1'b0};
  assign rxs = {2'b0, t_q} + {1'b0, p_q, 1'b0} - {2'b0, px_q} - {2'b0, qx_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    case (state_q)
      IDLE:  begin cnt_d = '0; if (in_valid) state_d = NUM; end
      NUM:   if (cnt_q == 4'd1)  begin cnt_d = '0; state_d = INV;   end
      INV:   if (cnt_q == 4'd11) begin cnt_d = '0; state_d = SLOPE; end
      SLOPE: begin cnt_d = '0; state_d = RX; end
      RX:    if (cnt_q == 4'd1)  begin cnt_d = '0; state_d = RY;    end
      RY:    if (cnt_q == 4'd1)  begin cnt_d = '0; state_d = OUT;   end
      OUT:   begin cnt_d = '0; state_d = IDLE; end
      default: begin cnt_d = '0; state_d = IDLE; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= '0; py_q <= '0; qx_q <= '0; qy_q <= '0; p_q <= '0; a_q <= '0;
      num_q <= '0; den_q <= '0; acc_q <= '0; s_q <= '0; t_q <= '0;
      rx_q <= '0; ry_q <= '0;
      out_valid_q <= 1'b0; out_rx_q <= '0; out_ry_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_rx_q    <= '0;
      out_ry_q    <= '0;
      case (state_q)
        IDLE: if (in_valid) begin
          px_q <= in_Px; py_q <= in_Py; qx_q <= in_Qx; qy_q <= in_Qy;
          p_q  <= in_prime; a_q <= in_a;
          acc_q <= W'(1);
        end
        NUM: begin
          if (cnt_q == 4'd0) begin
            t_q   <= mul_r;
            den_q <= dbl ? W'(y2 % {1'b0, p_q}) : sub_mod(qx_q, px_q, p_q);
            num_q <= sub_mod(qy_q, py_q, p_q);
          end else if (dbl) begin
            num_q <= W'(n3 % {3'b0, p_q});
          end
        end
        // Square on even slots, multiply by den on odd slots when the exponent bit is set
        INV: if (!cnt_q[0] || exp_bit) acc_q <= mul_r;
        SLOPE: s_q <= mul_r;
        RX: begin
          if (cnt_q == 4'd0) t_q <= mul_r;
          else               rx_q <= W'(rxs % {2'b0, p_q});
        end
        RY: begin
          if (cnt_q == 4'd0) t_q <= mul_r;
          else               ry_q <= sub_mod(t_q, py_q, p_q);
        end
        OUT: begin
          out_valid_q <= 1'b1;
          // A zero denominator means the point at infinity, encoded as (0,0)
          out_rx_q    <= degen ? '0 : rx_q;
          out_ry_q    <= degen ? '0 : ry_q;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_Rx    = 6'(out_rx_q);
  assign out_Ry    = 6'(out_ry_q);

endmodule

// File: tb/tb_ecc_point_add.sv
// Scoreboard bench for ecc_point_add: directed vectors plus a prime sweep against a brute-force model.
module tb_ecc_point_add;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [5:0] in_Px = '0, in_Py = '0, in_Qx = '0, in_Qy = '0, in_prime = '0, in_a = '0;
  logic out_valid;
  logic [5:0] out_Rx, out_Ry;

  ecc_point_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_Px(in_Px), .in_Py(in_Py), .in_Qx(in_Qx), .in_Qy(in_Qy),
    .in_prime(in_prime), .in_a(in_a),
    .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry)
  );

  always #5 clk = ~clk;

  typedef struct { int rx; int ry; int p; int t0; string name; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;

  always @(posedge clk) cyc++;

  // Monitor: compare each result against the queue head, and enforce zero outputs when idle
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got (%0d,%0d) with no pending request", out_Rx, out_Ry);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_Rx !== 6'(e.rx) || out_Ry !== 6'(e.ry) || (cyc - e.t0) != 21 ||
              int'(out_Rx) >= e.p || int'(out_Ry) >= e.p) begin
            fails++;
            $display("FAIL %s: got (%0d,%0d) lat %0d, want (%0d,%0d) lat 21 p=%0d",
                     e.name, out_Rx, out_Ry, cyc - e.t0, e.rx, e.ry, e.p);
          end
        end
      end else begin
        tests++;
        if (out_valid !== 1'b0 || out_Rx !== 6'd0 || out_Ry !== 6'd0) begin
          fails++;
          $display("FAIL idle_zero: valid=%b Rx=%0d Ry=%0d, want 0,0,0", out_valid, out_Rx, out_Ry);
        end
      end
    end
  end

  function automatic void model(input int p, a, px, py, qx, qy, output int rx, output int ry);
    int num, den, inv, s;
    if (px == qx && py == qy) begin
      num = (3 * px * px + a) % p;
      den = (2 * py) % p;
    end else begin
      num = ((qy - py) % p + p) % p;
      den = ((qx - px) % p + p) % p;
    end
    rx = 0; ry = 0;
    if (den == 0) return;
    inv = 0;
    for (int i = 1; i < p; i++) if ((den * i) % p == 1) inv = i;
    s  = (num * inv) % p;
    rx = ((s * s - px - qx) % p + p) % p;
    ry = ((s * (px - rx) - py) % p + p) % p;
  endfunction

  task automatic drive(input int p, a, px, py, qx, qy);
    in_prime = 6'(p); in_a = 6'(a);
    in_Px = 6'(px); in_Py = 6'(py); in_Qx = 6'(qx); in_Qy = 6'(qy);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after a negedge; the accepting edge is the next posedge
  task automatic issue(input string name, input int p, a, px, py, qx, qy, input int erx, ery);
    exp_t e;
    e.rx = erx; e.ry = ery; e.p = p; e.t0 = cyc; e.name = name;
    sb.push_back(e);
    drive(p, a, px, py, qx, qy);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: %0d results pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  int primes[17] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};

  initial begin
    #1;
    check("reset_valid", int'(out_valid), 0);
    check("reset_rx", int'(out_Rx), 0);
    check("reset_ry", int'(out_Ry), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // 1: add, 2: double (slope 13), 3: vertical line
    issue("add_17", 17, 2, 5, 1, 6, 3, 10, 6);
    wait_done("add_17");
    issue("dbl_17", 17, 2, 5, 1, 5, 1, 6, 3);
    wait_done("dbl_17");
    check("dbl_slope", int'(dut.s_q), 13);
    issue("vert_17", 17, 2, 5, 1, 5, 16, 0, 0);
    wait_done("vert_17");
    issue("dbl_y0", 17, 2, 5, 0, 5, 0, 0, 0);
    wait_done("dbl_y0");

    // 4: in_valid while busy is ignored; back-to-back after the strobe
    issue("busy_add", 17, 2, 5, 1, 6, 3, 10, 6);
    repeat (3) @(posedge clk);
    #1 drive(17, 2, 5, 1, 5, 1);
    wait_done("busy_add");
    issue("b2b_dbl", 17, 2, 5, 1, 5, 1, 6, 3);
    wait_done("b2b_dbl");

    // 5: reset mid-INV aborts, then a fresh op works
    @(negedge clk); #1;
    issue("aborted", 17, 2, 5, 1, 6, 3, 10, 6);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    issue("post_rst", 17, 2, 5, 1, 6, 3, 10, 6);
    wait_done("post_rst");

    // Reset during the out_valid cycle must clear the outputs immediately
    issue("pre_async", 17, 2, 5, 1, 6, 3, 10, 6);
    wait_done("pre_async");
    rst_n = 1'b0;
    #1;
    check("async_valid", int'(out_valid), 0);
    check("async_rx", int'(out_Rx), 0);
    check("async_ry", int'(out_Ry), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // 6: sweep across primes against the model
    for (int k = 0; k < 40; k++) begin
      int p, a, px, py, qx, qy, rx, ry;
      p  = primes[k % 17];
      a  = $urandom_range(p - 1);
      px = $urandom_range(p - 1); py = $urandom_range(p - 1);
      if (k % 4 == 1) begin qx = px; qy = py; end
      else if (k % 7 == 3) begin qx = px; qy = (p - py) % p; end
      else begin qx = $urandom_range(p - 1); qy = $urandom_range(p - 1); end
      model(p, a, px, py, qx, qy, rx, ry);
      issue($sformatf("sweep%0d_p%0d", k, p), p, a, px, py, qx, qy, rx, ry);
      wait_done("sweep");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
